fft_bitrev_buffer: RTL

//  Drives both ports of RAM_32x16 as the single initiator to reorder one frame of FFT samples.

---
 rtl/fft_bitrev_buffer_if.sv | 29 ++
 rtl/fft_bitrev_buffer.sv | 75 +++++++
 2 files changed

// File: rtl/fft_bitrev_buffer_if.sv
// fft_bitrev_buffer_if: sample stream handshakes and dual-port RAM wiring for the bit-reversal buffer
interface fft_bitrev_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              ram_ena;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dia;
  logic              ram_enb;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_dob;
  modport slave (
    input  in_valid, in_data, out_ready, ram_dob,
    output in_ready, out_valid, out_data, out_last,
    output ram_ena, ram_addra, ram_dia, ram_enb, ram_addrb
  );
  modport master (
    output in_valid, in_data, out_ready, ram_dob,
    input  in_ready, out_valid, out_data, out_last,
    input  ram_ena, ram_addra, ram_dia, ram_enb, ram_addrb
  );
endinterface

// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer: writes one frame into RAM at bit-reversed addresses, then streams it back in natural order
module fft_bitrev_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  fft_bitrev_buffer_if.slave io
);
  typedef enum logic {LOAD, DRAIN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d, rev;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [1:0]        last_q;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, wr_ptr_q;
  logic              in_fire, issue, pop, push;
  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign rev[i] = wr_cnt_q[ADDR_W-1-i];
  end
  always_comb begin
    in_fire         = state_q == LOAD && io.in_valid;
    pop             = count_q != 2'd0 && io.out_ready;
    push            = inflight_q;
    // a pop in this cycle frees a slot, which keeps the stream at one sample per cycle
    issue           = state_q == DRAIN && !rd_cnt_q[ADDR_W]
                      && ({1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
    state_d         = (in_fire && &wr_cnt_q) ? DRAIN
                    : (pop && last_q[rd_ptr_q]) ? LOAD : state_q;
    wr_cnt_d        = in_fire ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_cnt_d        = (pop && last_q[rd_ptr_q]) ? '0 : issue ? rd_cnt_q + 1'b1 : rd_cnt_q;
    inflight_d      = issue;
    inflight_last_d = issue && &rd_cnt_q[ADDR_W-1:0];
    count_d         = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= LOAD;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      mem_q[0]        <= '0;
      mem_q[1]        <= '0;
      last_q          <= '0;
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      rd_ptr_q        <= rd_ptr_q ^ pop;
      wr_ptr_q        <= wr_ptr_q ^ push;
      if (push) begin
        mem_q[wr_ptr_q]  <= io.ram_dob;
        last_q[wr_ptr_q] <= inflight_last_q;
      end
    end
  end
  assign io.in_ready  = state_q == LOAD;
  assign io.ram_ena   = in_fire;
  assign io.ram_addra = in_fire ? rev : '0;
  assign io.ram_dia   = in_fire ? io.in_data : '0;
  assign io.ram_enb   = issue;
  assign io.ram_addrb = issue ? rd_cnt_q[ADDR_W-1:0] : '0;
  assign io.out_valid = count_q != 2'd0;
  assign io.out_data  = mem_q[rd_ptr_q];
  assign io.out_last  = count_q != 2'd0 && last_q[rd_ptr_q];
endmodule
